// File: rtl/processor_control_unit_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, FSM state
// encodings, ALU function selects and instruction field positions.
package processor_control_unit_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;
  localparam logic [3:0] OP_PASS  = 4'd10;

  // Function selects understood by the ALU74381-style datapath ALU.
  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 8;
  localparam int RB_MSB   = 7;
  localparam int RB_LSB   = 4;
  localparam int RC_MSB   = 3;
  localparam int RC_LSB   = 0;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 4;

  // Encoding is fixed because the debug display decodes it directly.
  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ALU    = 4'd7,
    ST_HALT   = 4'd8
  } state_e;

  function automatic state_e decode_state(input logic [3:0] op);
    case (op)
      OP_NOOP:  return ST_NOOP;
      OP_STORE: return ST_STORE;
      OP_LOAD:  return ST_LOAD_A;
      OP_HALT:  return ST_HALT;
      OP_ADD, OP_SUB, OP_XOR, OP_OR,
      OP_AND, OP_INC, OP_PASS: return ST_ALU;
      default:  return ST_NOOP;  // unassigned opcodes behave as NOOP
    endcase
  endfunction

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_PASS: return ALU_PASS;
      OP_XOR:  return ALU_XOR;
      OP_OR:   return ALU_OR;
      OP_AND:  return ALU_AND;
      OP_INC:  return ALU_INC;
      default: return ALU_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/processor_control_unit_if.sv
// Control-unit <-> ROM/datapath bundle. The control unit is the master;
// the instruction ROM and datapath top level sit on the slave side.
interface processor_control_unit_if #(
  parameter int PC_W = 7
);
  logic [15:0]     IR_Data;
  logic [PC_W-1:0] PC_Addr;
  logic [7:0]      D_Addr;
  logic            D_Wr;
  logic            RF_s;
  logic [3:0]      RF_W_Addr;
  logic            RF_W_en;
  logic [3:0]      RF_Ra_Addr;
  logic [3:0]      RF_Rb_Addr;
  logic [2:0]      ALU_s0;
  logic            Halted;
  logic [3:0]      State;

  modport master (
    input  IR_Data,
    output PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, Halted, State
  );

  modport slave (
    output IR_Data,
    input  PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, Halted, State
  );
endinterface

// File: rtl/processor_control_unit_pc_counter.sv
// Program counter: synchronous clear and increment, wrapping modulo 2^PC_W.
module pc_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  // NOTE: combinational blocks assign a default first so no path leaves pc_d unassigned (no latch).
  always_comb begin
    pc_d = pc_q;
    if (clr_i)      pc_d = '0;
    else if (inc_i) pc_d = pc_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/processor_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit processor.
// Owns PC and IR; datapath controls are a Moore decode of state and IR.
module processor_control_unit
  import processor_control_unit_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  processor_control_unit_if.master  bus
);

  state_e          state_q;
  logic [15:0]     ir_q;
  logic [PC_W-1:0] pc;

  logic [3:0] op, ra, rb, rc;
  logic [7:0] mem_addr;

  assign op       = ir_q[OP_MSB:OP_LSB];
  assign ra       = ir_q[RA_MSB:RA_LSB];
  assign rb       = ir_q[RB_MSB:RB_LSB];
  assign rc       = ir_q[RC_MSB:RC_LSB];
  assign mem_addr = ir_q[ADDR_MSB:ADDR_LSB];

  // PC advances on the FETCH exit edge, so it already points past the
  // current instruction during DECODE and execute.
  pc_counter #(.PC_W(PC_W)) u_pc (
    .clk   (Clock),
    .rst_n (Resetn),
    .clr_i (state_q == ST_INIT),
    .inc_i (state_q == ST_FETCH),
    .pc_o  (pc)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_INIT;
      ir_q    <= '0;
    end else begin
      case (state_q)
        ST_INIT:   state_q <= ST_FETCH;
        ST_FETCH: begin
          ir_q    <= bus.IR_Data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: state_q <= decode_state(op);
        ST_LOAD_A: state_q <= ST_LOAD_B;  // wait out the synchronous data-memory read
        ST_HALT:   state_q <= ST_HALT;
        default:   state_q <= ST_FETCH;
      endcase
    end
  end

  // Decoded straight from the async-reset state, so a reset mid-instruction
  // drops every enable without waiting for a clock edge.
  always_comb begin
    bus.D_Addr     = '0;
    bus.D_Wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_Addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_Addr = '0;
    bus.RF_Rb_Addr = '0;
    bus.ALU_s0     = ALU_ZERO;
    case (state_q)
      ST_STORE: begin
        bus.D_Addr     = mem_addr;
        bus.RF_Ra_Addr = rc;
        bus.D_Wr       = 1'b1;
      end
      ST_LOAD_A: bus.D_Addr = mem_addr;
      ST_LOAD_B: begin
        bus.D_Addr    = mem_addr;
        bus.RF_s      = 1'b1;
        bus.RF_W_Addr = rc;
        bus.RF_W_en   = 1'b1;
      end
      ST_ALU: begin
        bus.RF_Ra_Addr = ra;
        bus.RF_Rb_Addr = rb;
        bus.RF_W_Addr  = rc;
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = alu_sel(op);
      end
      default: ;
    endcase
  end

  assign bus.PC_Addr = pc;
  assign bus.Halted  = (state_q == ST_HALT);
  assign bus.State   = state_q;

endmodule

// File: tb/tb_processor_control_unit.sv
// Self-checking bench for processor_control_unit: table-driven program with a
// scoreboard of per-execute-cycle expectations, plus directed corner sequences.
module tb_processor_control_unit;

  localparam int PC_W = 7;

  localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_NOOP = 4'd3, S_LOAD_A = 4'd4, S_LOAD_B = 4'd5,
                         S_STORE = 4'd6, S_ALU = 4'd7, S_HALT = 4'd8;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  st;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  wa;
    logic        we;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
    int          lat;
  } vec_t;

  typedef struct {
    int              idx;
    logic [3:0]      st;
    logic [PC_W-1:0] pc;
    logic [7:0]      d_addr;
    logic            d_wr;
    logic            rf_s;
    logic [3:0]      wa;
    logic            we;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [2:0]      alu;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [15:0] rom [128];

  processor_control_unit_if #(.PC_W(PC_W)) bus ();

  processor_control_unit #(.PC_W(PC_W)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  assign bus.IR_Data = rom[bus.PC_Addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  bit   mon_en = 1'b0;
  bit   prev_we = 1'b0;
  int   dwr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic compare_exec(input exp_t e);
    string p;
    p = $sformatf("v%0d_", e.idx);
    check({p, "state"},   32'(bus.State),   32'(e.st));
    check({p, "pc"},      32'(bus.PC_Addr), 32'(e.pc));
    check({p, "d_wr"},    32'(bus.D_Wr),    32'(e.d_wr));
    check({p, "rf_w_en"}, 32'(bus.RF_W_en), 32'(e.we));
    check({p, "alu_s0"},  32'(bus.ALU_s0),  32'(e.alu));
    if (e.st == S_STORE || e.st == S_LOAD_A || e.st == S_LOAD_B)
      check({p, "d_addr"}, 32'(bus.D_Addr), 32'(e.d_addr));
    if (e.st == S_STORE || e.st == S_ALU)
      check({p, "ra"}, 32'(bus.RF_Ra_Addr), 32'(e.ra));
    if (e.st == S_ALU)
      check({p, "rb"}, 32'(bus.RF_Rb_Addr), 32'(e.rb));
    if (e.st == S_LOAD_B || e.st == S_ALU) begin
      check({p, "wa"},   32'(bus.RF_W_Addr), 32'(e.wa));
      check({p, "rf_s"}, 32'(bus.RF_s),      32'(e.rf_s));
    end
  endtask

  // Monitor: pops one expectation per execute-phase cycle and enforces the
  // write-enable invariants on every cycle.
  always @(negedge clk) begin
    logic [3:0] st;
    logic       we;
    if (mon_en) begin
      st = bus.State;
      we = bus.D_Wr | bus.RF_W_en;
      if (st == S_FETCH || st == S_DECODE) check("no_we_in_fetch_decode", 32'(we), 32'd0);
      if (we) check("we_not_consecutive", 32'(prev_we), 32'd0);
      prev_we = we;
      if (bus.D_Wr) dwr_cnt++;
      if (st == S_NOOP || st == S_LOAD_A || st == S_LOAD_B || st == S_STORE || st == S_ALU) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: unexpected execute state %0d", st);
        end else begin
          compare_exec(sb.pop_front());
        end
      end
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic apply_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    check("rst_state",   32'(bus.State),   32'(S_INIT));
    check("rst_pc",      32'(bus.PC_Addr), 32'd0);
    check("rst_d_wr",    32'(bus.D_Wr),    32'd0);
    check("rst_rf_w_en", 32'(bus.RF_W_en), 32'd0);
    check("rst_alu_s0",  32'(bus.ALU_s0),  32'd0);
    check("rst_halted",  32'(bus.Halted),  32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    int exp_halt;
    exp_t e;

    //            instr     state    d_addr d_wr rf_s wa     we   ra     rb     alu   lat
    vecs[0]  = '{16'h3123, S_ALU,   8'h00, 1'b0, 1'b0, 4'h3, 1'b1, 4'h1, 4'h2, 3'd1, 3};
    vecs[1]  = '{16'h21A5, S_LOAD_B,8'h1A, 1'b0, 1'b1, 4'h5, 1'b1, 4'h0, 4'h0, 3'd0, 4};
    vecs[2]  = '{16'h1FF7, S_STORE, 8'hFF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h7, 4'h0, 3'd0, 3};
    vecs[3]  = '{16'h4567, S_ALU,   8'h00, 1'b0, 1'b0, 4'h7, 1'b1, 4'h5, 4'h6, 3'd2, 3};
    vecs[4]  = '{16'h6ABC, S_ALU,   8'h00, 1'b0, 1'b0, 4'hC, 1'b1, 4'hA, 4'hB, 3'd4, 3};
    vecs[5]  = '{16'h7123, S_ALU,   8'h00, 1'b0, 1'b0, 4'h3, 1'b1, 4'h1, 4'h2, 3'd5, 3};
    vecs[6]  = '{16'h8DEF, S_ALU,   8'h00, 1'b0, 1'b0, 4'hF, 1'b1, 4'hD, 4'hE, 3'd6, 3};
    vecs[7]  = '{16'h9340, S_ALU,   8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 4'h3, 4'h4, 3'd7, 3};
    vecs[8]  = '{16'hA890, S_ALU,   8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 4'h8, 4'h9, 3'd3, 3};
    vecs[9]  = '{16'hF123, S_NOOP,  8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 3};
    vecs[10] = '{16'h0000, S_NOOP,  8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 3};
    vecs[11] = '{16'hB456, S_NOOP,  8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 3};

    // ---- Table-driven program followed by HALT ----
    foreach (rom[i]) rom[i] = 16'h0000;
    apply_reset();
    exp_halt = 3;
    for (int i = 0; i < 12; i++) begin
      rom[i] = vecs[i].instr;
      exp_halt += vecs[i].lat;
      if (vecs[i].st == S_LOAD_B) begin
        e = '{i, S_LOAD_A, PC_W'(i + 1), vecs[i].d_addr, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0};
        sb.push_back(e);
      end
      e = '{i, vecs[i].st, PC_W'(i + 1), vecs[i].d_addr, vecs[i].d_wr, vecs[i].rf_s,
            vecs[i].wa, vecs[i].we, vecs[i].ra, vecs[i].rb, vecs[i].alu};
      sb.push_back(e);
    end
    rom[12] = 16'h5000;
    dwr_cnt = 0;

    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("c1_state_fetch", 32'(bus.State), 32'(S_FETCH));
    check("c1_pc", 32'(bus.PC_Addr), 32'd0);
    @(negedge clk);
    check("c2_state_decode", 32'(bus.State), 32'(S_DECODE));
    check("c2_pc", 32'(bus.PC_Addr), 32'd1);
    @(negedge clk);
    n = 3;
    while (bus.State != S_HALT && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("halt_latency", 32'(n), 32'(exp_halt));
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("store_cycles", 32'(dwr_cnt), 32'd1);

    // ---- HALT holds PC and blocks writes ----
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("halt%0d_pc", c), 32'(bus.PC_Addr), 32'd13);
      check($sformatf("halt%0d_flag", c), 32'(bus.Halted), 32'd1);
      check($sformatf("halt%0d_we", c), 32'(bus.D_Wr | bus.RF_W_en), 32'd0);
    end
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("halt_rst_state", 32'(bus.State), 32'(S_INIT));
    check("halt_rst_pc", 32'(bus.PC_Addr), 32'd0);
    check("halt_rst_halted", 32'(bus.Halted), 32'd0);

    // ---- PC wrap with NOOPs everywhere ----
    foreach (rom[i]) rom[i] = 16'h0000;
    apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (bus.PC_Addr != 7'd127 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("wrap_reach_127", 32'(bus.PC_Addr), 32'd127);
    n = 0;
    while (bus.PC_Addr == 7'd127 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wrap_pc_zero", 32'(bus.PC_Addr), 32'd0);
    check("wrap_state_decode", 32'(bus.State), 32'(S_DECODE));

    // ---- Reset during LOAD_B drops the write enable asynchronously ----
    rom[0] = 16'h21A5;
    apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (bus.State != S_LOAD_B && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("load_latency_to_b", 32'(n), 32'd4);
    check("loadb_we", 32'(bus.RF_W_en), 32'd1);
    check("loadb_rf_s", 32'(bus.RF_s), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("loadb_rst_we", 32'(bus.RF_W_en), 32'd0);
    check("loadb_rst_state", 32'(bus.State), 32'(S_INIT));
    check("loadb_rst_d_wr", 32'(bus.D_Wr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
